// File: rtl/instruction_fetch.sv
// instruction_fetch -- MIPS fetch stage.
// Holds the PC, fetches one instruction per issue over a req/ready handshake,
// presents opcode/funct to the control unit, resolves the next PC from the
// Branch/Jump/jump_reg controls and keeps a retired-instruction counter.
//
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned next PC at the accepting edge traps into FAULT
//   undefined : next_pc[1:0] is forced to 2'b00 and fault stays 0
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | request instruction at pc, wait for imem_ready
// ISSUE | instruction presented (instr_valid=1), wait for instr_accept
// FAULT | misaligned target trapped, everything held until reset
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_accept,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        branch_cond,
    input  logic [31:0] branch_offset,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] branch_target;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;
    logic        misaligned;

    assign imem_addr     = pc;
    assign pc_plus4      = pc + 32'd4;
    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign branch_target = pc_plus4 + (branch_offset << 2);

    // next-PC selection: Jump beats jump_reg beats taken branch beats fall-through
    always_comb begin
        next_pc_raw = pc_plus4;
        if (Jump)
            next_pc_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (jump_reg)
            next_pc_raw = jr_target;
        else if (Branch && branch_cond)
            next_pc_raw = branch_target;
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign next_pc    = next_pc_raw;
    assign misaligned = |next_pc_raw[1:0];
`else
    // low bits are dropped so the fetch address is always word aligned
    assign next_pc    = next_pc_raw & ~32'h0000_0003;
    assign misaligned = 1'b0;
`endif

    // fetch/issue sequencer with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            retired     <= 32'h0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // first cycle out of reset raises the request; afterwards
                    // the request is already up when we arrive here
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_accept) begin
                        pc          <= next_pc;
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        if (misaligned) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    fault       <= 1'b1;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS core. Holds the PC, fetches one instruction per issue from instruction memory over a req/ready handshake, and presents opcode/funct to the control unit. Computes the next PC from the control unit's Branch/Jump outputs plus the branch condition and register-jump target from execute. Keeps a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request; held until accepted.
- imem_addr  out  32  fetch address (= pc).
- imem_ready  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ready.
- instr_valid  out  1  instr/opcode/funct/pc valid for the current instruction.
- instr_accept  in  1  execute consumes the current instruction this cycle.
- instr  out  32  current instruction.
- opcode  out  6  instr[31:26], to control unit.
- funct  out  6  instr[5:0], to control unit.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, for the PC+4 write-back source.
- Branch  in  1  from control unit.
- Jump  in  1  from control unit.
- branch_cond  in  1  branch condition from ALU.
- branch_offset  in  32  sign-extended immediate (word offset).
- jump_reg  in  1  register jump (jr/jalr).
- jr_target  in  32  register jump target.
- fault  out  1  misaligned-target fault (see Configuration).
- retired  out  32  count of accepted instructions.

## Operation
- States: FETCH, ISSUE, FAULT.
- FETCH: imem_req=1, imem_addr=pc. On a clock edge with imem_ready=1: instr<=imem_rdata, go to ISSUE.
- ISSUE: instr_valid=1, imem_req=0, outputs stable. On a clock edge with instr_accept=1: pc<=next_pc, retired<=retired+1, go to FETCH. instr_accept=0 holds ISSUE indefinitely.
- instr_accept outside ISSUE is ignored.
- next_pc priority:
  - Jump → {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else jump_reg → jr_target.
  - else Branch&branch_cond → pc_plus4 + (branch_offset<<2).
  - else pc_plus4.
- All next-PC arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0.
- retired wraps from 32'hFFFF_FFFF to 0.
- opcode, funct and pc_plus4 are combinational from instr and pc.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH, instr=0, retired=0.
  - imem_req=1 from the first cycle after reset deasserts.
  - instr_valid=0, fault=0.
- Reset is asynchronous. Asserting it mid-fetch or mid-issue immediately drops instr_valid and returns all state to reset values; the pending fetch is abandoned.
- Latency with imem_ready tied high and instr_accept tied high: 2 cycles per instruction (FETCH then ISSUE).
- Each memory wait cycle adds one FETCH cycle. imem_addr stays constant while imem_req=1.
- Branch/Jump/branch_cond/jump_reg are sampled only at the accepting edge.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined:
  - If next_pc[1:0]≠0 at the accepting edge, go to FAULT. The counter still increments for the faulting instruction.
  - FAULT holds fault=1, imem_req=0, instr_valid=0 until reset.
- IFETCH_MISALIGN_TRAP_EN undefined:
  - next_pc[1:0] is forced to 2'b00. fault is tied 0. FAULT is unreachable.

## Test plan
- Reset with RESET_PC=32'h0040_0000, memory always ready → imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_valid high every second cycle; retired=3 after three accepts.
- Branch=1, branch_cond=1, branch_offset=32'hFFFF_FFFF at pc=0x100 → next imem_addr=0x100. With branch_cond=0 → 0x104.
- Jump=1, instr[25:0]=26'h0000010, pc=0x1000_0000 → next imem_addr=0x1000_0040. With Jump and jump_reg both high, Jump wins.
- imem_ready low for 3 cycles, then instr_accept low for 2 cycles in ISSUE → imem_addr stable throughout the wait, instr stable throughout the hold, retired unchanged until the accept.
- jump_reg with jr_target=0x0000_0102:
  - With the macro: fault=1 and imem_req=0 permanently after the accept.
  - Without the macro: next imem_addr=0x0000_0100.
- rst_n asserted while in FETCH with memory stalled → imem_req=0, instr_valid=0, pc=RESET_PC immediately, without waiting for a clock edge.
